jfpjc_byte_stuffer: RTL and testbench
=====================================

Name: jfpjc_byte_stuffer

Overview:
- Downstream of the jfpjc bit packer. Consumes its 32-bit packed entropy-coded words and serialises them into a JPEG scan byte stream.
- Inserts the mandatory 0x00 after every 0xFF data byte, which moves stuffing out of the bench and into RTL.
- Honours a final partial word at end of frame and feeds a byte-wide sink (UART/SPI/FIFO) through a valid/ready handshake.

Parameters:
- COUNT_WIDTH, 24, width of the emitted-byte counter (must hold ≥ 320*240*2).

Ports:
- clock  input  1  system clock, rising edge
- nreset  input  1  synchronous active-low reset
- word_in  input  32  packed word; byte 0 = word_in[7:0] is sent first, byte 3 = [31:24] last
- word_in_valid  input  1  word_in is valid
- word_in_last  input  1  word is the final word of the frame; qualified by word_in_valid
- word_in_nbytes  input  3  valid bytes in a last word, 1..4; ignored unless word_in_last
- word_in_ready  output  1  block accepts word_in this cycle
- byte_out  output  8  stream byte
- byte_out_valid  output  1  byte_out valid
- byte_out_last  output  1  final byte of the frame
- byte_out_ready  input  1  sink accepts byte_out
- bytes_emitted  output  COUNT_WIDTH  bytes handed off this frame, including stuffed bytes

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-low, sampled on the rising edge of clock.
  - While nreset=0: state=IDLE; word_in_ready=0; byte_out_valid=0; byte_out_last=0; byte_out=8'h00; bytes_emitted=0; word and byte index registers cleared.
  - First cycle after reset release: word_in_ready=1.
  - Reset mid-word or mid-stuff discards the held word. No partial byte, stuff byte or EOI is emitted afterwards.
- Handshakes:
  - Input transfer occurs when word_in_valid & word_in_ready. Output transfer occurs when byte_out_valid & byte_out_ready.
  - byte_out, byte_out_valid and byte_out_last are registered and stay stable while valid & !ready.
  - word_in_ready is 1 only in IDLE (single-word holding register, one bubble per word).
- States:
  - IDLE: word_in_ready=1.
    - On input transfer: latch the word, set limit = word_in_last ? word_in_nbytes : 4, latch the last flag, set idx=0.
    - Next cycle: byte_out = byte[0], valid=1, state EMIT.
    - word_in_nbytes of 0 or >4 is treated as 4.
  - EMIT: on output transfer of byte[idx]:
    - If byte[idx]==8'hFF: next byte_out = 8'h00, go to STUFF.
    - Else if idx+1 < limit: present byte[idx+1].
    - Else the word is done: go to FINISH.
  - STUFF: on output transfer of the 0x00, continue as EMIT does for a non-FF byte (next byte or FINISH).
  - FINISH (combinational decision, no extra cycle):
    - Not last: valid=0, state IDLE.
    - Last: end of frame as described under Optional Feature.
- Latency and throughput:
  - Word accepted in cycle N gives its first byte valid in cycle N+1.
  - With sink always ready: bytes_per_word + number_of_0xFF + 1 cycles per word.
- bytes_emitted:
  - Increments by 1 on every output transfer, including stuffed 0x00 and EOI bytes.
  - Cleared on the first input transfer after a frame completed (byte_out_last transfer).
  - Saturates at all-ones and never wraps.
- byte_out_last:
  - Set together with the final byte of the frame.
  - A 0xFF final data byte is never last; its stuffed 0x00 (or the EOI) carries last.
- Simultaneous events: an input transfer cannot coincide with an output transfer because ready is only asserted in IDLE, where valid=0.

Optional Feature:
- Macro JFPJC_STUFFER_EOI_EN.
- Defined:
  - After the last data or stuff byte of a last word, append the unstuffed EOI marker 8'hFF then 8'hD9 (states EOI_FF and EOI_D9).
  - byte_out_last is asserted only with 8'hD9.
  - The EOI 0xFF is not followed by 0x00.
- Undefined:
  - No EOI; last is asserted on the final data byte, or on its stuffed 0x00.
  - EOI states are not compiled.

Test Plan:
- Word 32'h44332211, last=1, nbytes=4, sink always ready -> bytes 11 22 33 44; last on 44 (or on D9 after FF D9 with EOI_EN); bytes_emitted=4 (6 with EOI_EN).
- Word 32'hFF00FFAB, not last -> AB FF 00 00 FF 00; valid contiguous for 6 cycles, then 1 idle cycle; bytes_emitted=6.
- Last word 32'h000000FF, nbytes=1 -> FF 00 with last on 00 (EOI_EN: FF 00 FF D9, last on D9).
- Sink ready toggling 1/0 while streaming 32'hFFFFFFFF -> byte_out held stable on each stall; output exactly FF 00 repeated 4 times with no loss or duplication.
- nreset pulled low for 1 cycle mid-STUFF, then new word 32'h04030201 last nbytes=4 -> no 00 or old bytes appear; output 01 02 03 04; bytes_emitted restarts from 0.
- Back-to-back frames -> bytes_emitted clears on the first word of the second frame; last asserted exactly once per frame.

Source files
------------

// File: rtl/jfpjc_byte_stuffer.sv
// jfpjc_byte_stuffer: serialises 32-bit packed entropy-coded words into a
// JPEG scan byte stream, byte 0 (word_in[7:0]) first. A 0x00 is inserted
// after every 0xFF data byte. A single-word holding register accepts a new
// word only in IDLE. Output handshake is valid/ready with registered outputs.
// Optional feature: define JFPJC_STUFFER_EOI_EN to append the EOI marker
// (FF D9, not stuffed) after the last word of a frame.
module jfpjc_byte_stuffer #(
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic [31:0]            word_in,
  input  logic                   word_in_valid,
  input  logic                   word_in_last,
  input  logic [2:0]             word_in_nbytes,
  output logic                   word_in_ready,
  output logic [7:0]             byte_out,
  output logic                   byte_out_valid,
  output logic                   byte_out_last,
  input  logic                   byte_out_ready,
  output logic [COUNT_WIDTH-1:0] bytes_emitted
);

`ifdef JFPJC_STUFFER_EOI_EN
  localparam bit EoiEn = 1'b1;
`else
  localparam bit EoiEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EMIT   = 3'd1,
`ifdef JFPJC_STUFFER_EOI_EN
    S_STUFF  = 3'd2,
    S_EOI_FF = 3'd3,
    S_EOI_D9 = 3'd4
`else
    S_STUFF  = 3'd2
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            word_q, word_d;
  logic [2:0]             limit_q, limit_d;
  logic                   last_word_q, last_word_d;
  logic [1:0]             idx_q, idx_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   blast_q, blast_d;
  logic                   ready_q, ready_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   frame_done_q, frame_done_d;

  logic                   in_xfer;
  logic                   out_xfer;
  logic [2:0]             limit_in;
  logic [1:0]             next_idx;
  logic [7:0]             next_byte;
  logic                   has_next;
  logic                   next_is_final;
  logic                   advance;

  assign word_in_ready  = ready_q;
  assign byte_out       = byte_q;
  assign byte_out_valid = valid_q;
  assign byte_out_last  = blast_q;
  assign bytes_emitted  = count_q;

  // Handshake qualifiers and byte-position helpers for the held word.
  always_comb begin
    in_xfer       = word_in_valid & ready_q;
    out_xfer      = valid_q & byte_out_ready;
    limit_in      = 3'd4;
    if (word_in_last && (word_in_nbytes != 3'd0) && (word_in_nbytes <= 3'd4)) begin
      limit_in = word_in_nbytes;
    end
    next_idx      = idx_q + 2'd1;
    next_byte     = word_q[{next_idx, 3'b000} +: 8];
    has_next      = (({1'b0, idx_q} + 3'd1) < limit_q);
    next_is_final = last_word_q && (({1'b0, idx_q} + 3'd2) == limit_q);
  end

  // Next-state and next-output computation for the stuffing FSM.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    limit_d      = limit_q;
    last_word_d  = last_word_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    valid_d      = valid_q;
    blast_d      = blast_q;
    ready_d      = ready_q;
    count_d      = count_q;
    frame_done_d = frame_done_q;
    advance      = 1'b0;

    if (out_xfer) begin
      if (count_q != '1) begin
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (blast_q) begin
        frame_done_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        blast_d = 1'b0;
        if (in_xfer) begin
          word_d      = word_in;
          limit_d     = limit_in;
          last_word_d = word_in_last;
          idx_d       = 2'd0;
          byte_d      = word_in[7:0];
          valid_d     = 1'b1;
          blast_d     = !EoiEn && word_in_last && (limit_in == 3'd1) &&
                        (word_in[7:0] != 8'hFF);
          ready_d     = 1'b0;
          state_d     = S_EMIT;
          if (frame_done_q) begin
            count_d      = '0;
            frame_done_d = 1'b0;
          end
        end
      end
      S_EMIT: begin
        if (out_xfer) begin
          if (byte_q == 8'hFF) begin
            byte_d  = 8'h00;
            blast_d = !EoiEn && last_word_q && !has_next;
            state_d = S_STUFF;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_STUFF: begin
        if (out_xfer) begin
          state_d = S_EMIT;
          advance = 1'b1;
        end
      end
`ifdef JFPJC_STUFFER_EOI_EN
      S_EOI_FF: begin
        if (out_xfer) begin
          byte_d  = 8'hD9;
          blast_d = 1'b1;
          state_d = S_EOI_D9;
        end
      end
      S_EOI_D9: begin
        if (out_xfer) begin
          valid_d = 1'b0;
          blast_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        blast_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Shared by EMIT (non-FF byte) and STUFF: present the next byte or
    // finish the word without spending an extra cycle.
    if (advance) begin
      if (has_next) begin
        idx_d   = next_idx;
        byte_d  = next_byte;
        blast_d = !EoiEn && next_is_final && (next_byte != 8'hFF);
      end else begin
`ifdef JFPJC_STUFFER_EOI_EN
        if (last_word_q) begin
          byte_d  = 8'hFF;
          blast_d = 1'b0;
          state_d = S_EOI_FF;
        end else begin
          valid_d = 1'b0;
          blast_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
`else
        valid_d = 1'b0;
        blast_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
`endif
      end
    end
  end

  // State and registered outputs; reset discards any held word.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      limit_q      <= '0;
      last_word_q  <= 1'b0;
      idx_q        <= '0;
      byte_q       <= 8'h00;
      valid_q      <= 1'b0;
      blast_q      <= 1'b0;
      ready_q      <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      limit_q      <= limit_d;
      last_word_q  <= last_word_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      valid_q      <= valid_d;
      blast_q      <= blast_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_jfpjc_byte_stuffer.sv
// Self-checking bench for jfpjc_byte_stuffer. Expected bytes are pushed to a
// scoreboard queue when each word is driven; observed transfers are popped
// and compared. Honours JFPJC_STUFFER_EOI_EN when compiled with it.
module tb_jfpjc_byte_stuffer;

  localparam int unsigned CW = 24;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic [31:0]   word_in = '0;
  logic          word_in_valid = 1'b0;
  logic          word_in_last = 1'b0;
  logic [2:0]    word_in_nbytes = 3'd4;
  logic          word_in_ready;
  logic [7:0]    byte_out;
  logic          byte_out_valid;
  logic          byte_out_last;
  logic          byte_out_ready = 1'b1;
  logic [CW-1:0] bytes_emitted;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];    // {last, byte}
  logic [8:0]  obs_q[$];    // {last, byte}
  logic [9:0]  trace_q[$];  // {ready, last, byte} for every valid cycle
  int unsigned em_model = 0;
  bit          model_done = 1'b0;

`ifdef JFPJC_STUFFER_EOI_EN
  localparam int unsigned EOI_EXTRA = 2;
`else
  localparam int unsigned EOI_EXTRA = 0;
`endif

  jfpjc_byte_stuffer #(.COUNT_WIDTH(CW)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .word_in        (word_in),
    .word_in_valid  (word_in_valid),
    .word_in_last   (word_in_last),
    .word_in_nbytes (word_in_nbytes),
    .word_in_ready  (word_in_ready),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_last  (byte_out_last),
    .byte_out_ready (byte_out_ready),
    .bytes_emitted  (bytes_emitted)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference model: expected byte stream and emitted count for one word.
  function automatic void model_push(input logic [31:0] w, input bit last,
                                     input logic [2:0] nb);
    int unsigned lim;
    int unsigned n;
    logic [7:0]  b;
    bit          fin;
    lim = 4;
    if (last && nb >= 3'd1 && nb <= 3'd4) lim = int'(nb);
    n = 0;
    if (model_done) begin
      em_model   = 0;
      model_done = 1'b0;
    end
    for (int unsigned i = 0; i < lim; i++) begin
      b = 8'(w >> (8 * i));
`ifdef JFPJC_STUFFER_EOI_EN
      fin = 1'b0;
`else
      fin = last && (i == lim - 1);
`endif
      if (b == 8'hFF) begin
        exp_q.push_back({1'b0, b});
        exp_q.push_back({fin, 8'h00});
        n += 2;
      end else begin
        exp_q.push_back({fin, b});
        n += 1;
      end
    end
`ifdef JFPJC_STUFFER_EOI_EN
    if (last) begin
      exp_q.push_back({1'b0, 8'hFF});
      exp_q.push_back({1'b1, 8'hD9});
      n += 2;
    end
`endif
    em_model += n;
    if (last) model_done = 1'b1;
  endfunction

  function automatic void model_reset();
    em_model   = 0;
    model_done = 1'b0;
    exp_q.delete();
  endfunction

  // Drive one word; called at a negedge, returns at the negedge after accept.
  task automatic send_word(input logic [31:0] w, input bit last, input logic [2:0] nb);
    int unsigned n = 0;
    while (!word_in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    word_in        = w;
    word_in_last   = last;
    word_in_nbytes = nb;
    word_in_valid  = 1'b1;
    @(negedge clock);
    word_in_valid  = 1'b0;
  endtask

  // Step the sink until the block is ready for the next word.
  // mode 0: sink always ready; mode 1: ready toggles 1/0 starting at 1.
  task automatic collect(input int mode, output int unsigned cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    forever begin
      byte_out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (byte_out_valid) begin
        trace_q.push_back({byte_out_ready, byte_out_last, byte_out});
        if (byte_out_ready) obs_q.push_back({byte_out_last, byte_out});
      end
      if (word_in_ready) break;
      if (cyc >= 200) begin
        to = 1'b1;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    byte_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({word_in_ready, byte_out_valid, byte_out_last} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got ready/valid/last=%b required=000",
               {word_in_ready, byte_out_valid, byte_out_last});
    end
    checks++;
    if (byte_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_byte got=%h required=00", byte_out);
    end
    checks++;
    if (bytes_emitted !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d required=0", bytes_emitted);
    end
    nreset = 1'b1;
    @(negedge clock);
    checks++;
    if (word_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=1", word_in_ready);
    end
    model_reset();
  endtask

  task automatic test_single_word();
    int unsigned cyc;
    bit to;
    logic [8:0] e, o;
    obs_q.delete();
    model_push(32'h44332211, 1'b1, 3'd4);
    send_word(32'h44332211, 1'b1, 3'd4);
    collect(0, cyc, to);
    checks++;
    if (to || cyc != 4 + EOI_EXTRA) begin
      failures++;
      $display("FAIL single_cycles got=%0d timeout=%b required=%0d", cyc, to, 4 + EOI_EXTRA);
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL single_stream missing got=none required=%h", e);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL single_stream extra got=%h required=none", o);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL single_stream got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (bytes_emitted !== CW'(em_model)) begin
      failures++;
      $display("FAIL single_count got=%0d required=%0d", bytes_emitted, em_model);
    end
  endtask

  task automatic test_stuffing();
    int unsigned cyc;
    bit to;
    logic [8:0] e, o;
    obs_q.delete();
    trace_q.delete();
    model_push(32'hFF00FFAB, 1'b0, 3'd4);
    send_word(32'hFF00FFAB, 1'b0, 3'd4);
    collect(0, cyc, to);
    checks++;
    if (to || cyc != 6 || trace_q.size() != 6) begin
      failures++;
      $display("FAIL stuff_contiguous got cycles=%0d valid=%0d timeout=%b required=6/6",
               cyc, trace_q.size(), to);
    end
    checks++;
    if (bytes_emitted !== CW'(6)) begin
      failures++;
      $display("FAIL stuff_count got=%0d required=6", bytes_emitted);
    end
    model_push(32'h000000FF, 1'b1, 3'd1);
    send_word(32'h000000FF, 1'b1, 3'd1);
    collect(0, cyc, to);
    checks++;
    if (to || cyc != 2 + EOI_EXTRA) begin
      failures++;
      $display("FAIL stuff_last_cycles got=%0d timeout=%b required=%0d", cyc, to, 2 + EOI_EXTRA);
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL stuff_stream missing got=none required=%h", e);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL stuff_stream extra got=%h required=none", o);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL stuff_stream got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (bytes_emitted !== CW'(em_model)) begin
      failures++;
      $display("FAIL stuff_last_count got=%0d required=%0d", bytes_emitted, em_model);
    end
  endtask

  task automatic test_stall();
    int unsigned cyc;
    int unsigned stalls;
    bit to;
    logic [8:0] e, o;
    obs_q.delete();
    trace_q.delete();
    model_push(32'hFFFFFFFF, 1'b0, 3'd4);
    send_word(32'hFFFFFFFF, 1'b0, 3'd4);
    collect(1, cyc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL stall_timeout got=timeout required=word completes");
    end
    stalls = 0;
    for (int i = 0; i + 1 < trace_q.size(); i++) begin
      if (trace_q[i][9] == 1'b0) begin
        stalls++;
        checks++;
        if (trace_q[i+1][8:0] !== trace_q[i][8:0]) begin
          failures++;
          $display("FAIL stall_hold idx=%0d got=%h required=%h", i, trace_q[i+1][8:0], trace_q[i][8:0]);
        end
      end
    end
    checks++;
    if (stalls != 7) begin
      failures++;
      $display("FAIL stall_count got=%0d required=7", stalls);
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL stall_stream missing got=none required=%h", e);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL stall_stream extra got=%h required=none", o);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL stall_stream got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (bytes_emitted !== CW'(8)) begin
      failures++;
      $display("FAIL stall_emitted got=%0d required=8", bytes_emitted);
    end
  endtask

  task automatic test_reset_mid_stuff();
    int unsigned cyc;
    bit to;
    logic [8:0] e, o;
    obs_q.delete();
    byte_out_ready = 1'b1;
    send_word(32'h000000FF, 1'b0, 3'd4);
    @(negedge clock);
    checks++;
    if ({byte_out_valid, byte_out} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL midstuff_pre got valid/byte=%b/%h required=1/00", byte_out_valid, byte_out);
    end
    byte_out_ready = 1'b0;
    nreset = 1'b0;
    @(negedge clock);
    checks++;
    if ({byte_out_valid, word_in_ready, bytes_emitted} !== {1'b0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL midstuff_reset got valid=%b ready=%b count=%0d required=0/0/0",
               byte_out_valid, word_in_ready, bytes_emitted);
    end
    nreset = 1'b1;
    byte_out_ready = 1'b1;
    @(negedge clock);
    model_reset();
    model_push(32'h04030201, 1'b1, 3'd4);
    send_word(32'h04030201, 1'b1, 3'd4);
    collect(0, cyc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midstuff_timeout got=timeout required=word completes");
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL midstuff_stream missing got=none required=%h", e);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL midstuff_stream extra got=%h required=none", o);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL midstuff_stream got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (bytes_emitted !== CW'(4 + EOI_EXTRA)) begin
      failures++;
      $display("FAIL midstuff_count got=%0d required=%0d", bytes_emitted, 4 + EOI_EXTRA);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned cyc;
    int unsigned lasts_sent;
    int unsigned lasts_seen;
    bit to;
    bit any_to;
    logic [8:0] e, o;
    logic [31:0] w;
    bit lst;
    logic [2:0] nb;
    obs_q.delete();
    lasts_sent = 0;
    any_to = 1'b0;
    // Frame A: one full last word.
    model_push(32'hAABBCCDD, 1'b1, 3'd4); lasts_sent++;
    send_word(32'hAABBCCDD, 1'b1, 3'd4);
    collect(0, cyc, to); any_to |= to;
    // Frame B: first word must clear the count from frame A.
    model_push(32'h00FF1234, 1'b0, 3'd4);
    send_word(32'h00FF1234, 1'b0, 3'd4);
    checks++;
    if (bytes_emitted !== CW'(0)) begin
      failures++;
      $display("FAIL b2b_clear got=%0d required=0", bytes_emitted);
    end
    collect(0, cyc, to); any_to |= to;
    model_push(32'h0000FF77, 1'b1, 3'd2); lasts_sent++;
    send_word(32'h0000FF77, 1'b1, 3'd2);
    collect(0, cyc, to); any_to |= to;
    checks++;
    if (bytes_emitted !== CW'(em_model)) begin
      failures++;
      $display("FAIL b2b_frameb_count got=%0d required=%0d", bytes_emitted, em_model);
    end
    // nbytes boundaries: 0 and 7 behave as 4, 3 is a partial word.
    model_push(32'h55FFAA99, 1'b1, 3'd0); lasts_sent++;
    send_word(32'h55FFAA99, 1'b1, 3'd0);
    collect(0, cyc, to); any_to |= to;
    model_push(32'h12345678, 1'b1, 3'd7); lasts_sent++;
    send_word(32'h12345678, 1'b1, 3'd7);
    collect(0, cyc, to); any_to |= to;
    model_push(32'hDDCCBBAA, 1'b1, 3'd3); lasts_sent++;
    send_word(32'hDDCCBBAA, 1'b1, 3'd3);
    collect(0, cyc, to); any_to |= to;
    checks++;
    if (bytes_emitted !== CW'(3 + EOI_EXTRA)) begin
      failures++;
      $display("FAIL b2b_partial_count got=%0d required=%0d", bytes_emitted, 3 + EOI_EXTRA);
    end
    // Random words, biased towards 0xFF bytes, sink ready toggling.
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 4; j++) begin
        w[8*j +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      lst = ($urandom_range(0, 2) == 0) || (k == 11);
      nb  = 3'($urandom_range(0, 7));
      if (lst) lasts_sent++;
      model_push(w, lst, nb);
      send_word(w, lst, nb);
      collect(k % 2, cyc, to); any_to |= to;
    end
    checks++;
    if (any_to) begin
      failures++;
      $display("FAIL b2b_timeout got=timeout required=all words complete");
    end
    checks++;
    if (bytes_emitted !== CW'(em_model)) begin
      failures++;
      $display("FAIL b2b_final_count got=%0d required=%0d", bytes_emitted, em_model);
    end
    lasts_seen = 0;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL b2b_stream missing got=none required=%h", e);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL b2b_stream extra got=%h required=none", o);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o[8]) lasts_seen++;
        if (o !== e) begin
          failures++;
          $display("FAIL b2b_stream got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (lasts_seen != lasts_sent) begin
      failures++;
      $display("FAIL b2b_last_count got=%0d required=%0d", lasts_seen, lasts_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stuffing();
    test_stall();
    test_reset_mid_stuff();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
